// File: rtl/uart_cmd_parser.sv
// Purpose: decodes 6-byte UART command frames (HEAD, CMD, A2, A1, A0, CHK) into cmd/addr with an XOR checksum.
// Latency: o_cmd_vld / o_err pulse 1 cycle after the CHK byte strobe; o_timeout 1 cycle after the terminal count.
// Backpressure: none; every i_rx_vld strobe is consumed, including back-to-back strobes on consecutive cycles.
module uart_cmd_parser #(
    parameter logic [7:0]  HEAD        = 8'h55,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_vld,
    output logic [7:0]  o_cmd,
    output logic [23:0] o_addr,
    output logic        o_cmd_vld,
    output logic        o_err,
    output logic        o_timeout,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR2,
        S_ADDR1,
        S_ADDR0,
        S_CHK
    } state_t;

    // Counter value at which an idle gap inside a frame aborts it.
    localparam logic [15:0] TERM = TIMEOUT_CYC - 16'd1;

    state_t      state;
    state_t      state_nx;
    logic [15:0] tmo_cnt;
    logic [7:0]  chk_acc;
    logic [7:0]  cmd_sh;
    logic [23:0] addr_sh;
    logic        term_hit;
    logic        good_nx;
    logic        bad_nx;
    logic        tmo_nx;

    // A strobe in the terminal-count cycle suppresses the timeout: the byte wins.
    assign term_hit = (state != S_IDLE) && !i_rx_vld && (tmo_cnt == TERM);
    assign o_busy   = (state != S_IDLE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and frame-result strobes; one state per accepted byte, no mid-frame resync on HEAD.
    always_comb begin
        state_nx = state;
        good_nx  = 1'b0;
        bad_nx   = 1'b0;
        tmo_nx   = 1'b0;
        if (term_hit) begin
            state_nx = S_IDLE;
            tmo_nx   = 1'b1;
        end else if (i_rx_vld) begin
            case (state)
                S_IDLE:  if (i_rx_data == HEAD) state_nx = S_CMD;
                S_CMD:   state_nx = S_ADDR2;
                S_ADDR2: state_nx = S_ADDR1;
                S_ADDR1: state_nx = S_ADDR0;
                S_ADDR0: state_nx = S_CHK;
                S_CHK: begin
                    state_nx = S_IDLE;
                    if (i_rx_data == chk_acc) good_nx = 1'b1;
                    else                      bad_nx  = 1'b1;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Inter-byte timeout counter: held at zero while idle and restarted by every strobe.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tmo_cnt <= 16'd0;
        end else if (i_rx_vld || (state == S_IDLE) || term_hit) begin
            tmo_cnt <= 16'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Shadow capture and running checksum; a timeout discards the partial frame.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            chk_acc <= 8'h00;
            cmd_sh  <= 8'h00;
            addr_sh <= 24'h000000;
        end else if (term_hit) begin
            chk_acc <= 8'h00;
            cmd_sh  <= 8'h00;
            addr_sh <= 24'h000000;
        end else if (i_rx_vld) begin
            case (state)
                S_IDLE:  if (i_rx_data == HEAD) chk_acc <= 8'h00;
                S_CMD: begin
                    cmd_sh  <= i_rx_data;
                    chk_acc <= chk_acc ^ i_rx_data;
                end
                S_ADDR2: begin
                    addr_sh[23:16] <= i_rx_data;
                    chk_acc        <= chk_acc ^ i_rx_data;
                end
                S_ADDR1: begin
                    addr_sh[15:8] <= i_rx_data;
                    chk_acc       <= chk_acc ^ i_rx_data;
                end
                S_ADDR0: begin
                    addr_sh[7:0] <= i_rx_data;
                    chk_acc      <= chk_acc ^ i_rx_data;
                end
                default: ;
            endcase
        end
    end

    // Registered results: cmd/addr only move on a good frame and hold otherwise.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_cmd     <= 8'h00;
            o_addr    <= 24'h000000;
            o_cmd_vld <= 1'b0;
            o_err     <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            o_cmd_vld <= good_nx;
            o_err     <= bad_nx;
            o_timeout <= tmo_nx;
            if (good_nx) begin
                o_cmd  <= cmd_sh;
                o_addr <= addr_sh;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Purpose: self-checking bench for uart_cmd_parser (frame table, hand sequences, random traffic vs. frame model).
// Latency: compares every cycle at the falling edge against a byte-level frame model.
// Backpressure: n/a; stimulus drives one strobe or idle per cycle.
module tb_uart_cmd_parser;

    localparam logic [15:0] TMO = 16'd100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_vld;
    logic [7:0]  o_cmd;
    logic [23:0] o_addr;
    logic        o_cmd_vld;
    logic        o_err;
    logic        o_timeout;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;

    uart_cmd_parser #(
        .HEAD        (8'h55),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .i_rx_data (rx_data),
        .i_rx_vld  (rx_vld),
        .o_cmd     (o_cmd),
        .o_addr    (o_addr),
        .o_cmd_vld (o_cmd_vld),
        .o_err     (o_err),
        .o_timeout (o_timeout),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    // Frame model: collects the bytes following HEAD and judges the frame when five have arrived.
    bit          m_in_frame;
    logic [7:0]  m_bytes[$];
    int          m_idle;
    logic [7:0]  m_cmd;
    logic [23:0] m_addr;
    logic        m_vld;
    logic        m_err;
    logic        m_tmo;

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_bytes.delete();
        m_idle = 0;
        m_cmd  = 8'h00;
        m_addr = 24'h000000;
        m_vld  = 1'b0;
        m_err  = 1'b0;
        m_tmo  = 1'b0;
    endfunction

    function automatic void model_clock(input logic vld, input logic [7:0] d);
        m_vld = 1'b0;
        m_err = 1'b0;
        m_tmo = 1'b0;
        if (vld) begin
            m_idle = 0;
            if (!m_in_frame) begin
                if (d == 8'h55) begin
                    m_in_frame = 1'b1;
                    m_bytes.delete();
                end
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 5) begin
                    m_in_frame = 1'b0;
                    if ((m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3]) == m_bytes[4]) begin
                        m_vld  = 1'b1;
                        m_cmd  = m_bytes[0];
                        m_addr = {m_bytes[1], m_bytes[2], m_bytes[3]};
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == int'(TMO)) begin
                m_in_frame = 1'b0;
                m_idle     = 0;
                m_tmo      = 1'b1;
            end
        end
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock: drive at the falling edge, advance the model on the rising edge, compare at the next falling edge.
    task automatic step(input logic vld, input logic [7:0] d);
        rx_vld  = vld;
        rx_data = d;
        @(posedge clk);
        model_clock(vld, d);
        @(negedge clk);
        check("cycle", 64'({o_cmd_vld, o_err, o_timeout, o_busy, o_cmd, o_addr}),
              64'({m_vld, m_err, m_tmo, m_in_frame, m_cmd, m_addr}));
    endtask

    task automatic send_frame(input logic [47:0] f, input int gap);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, f[47 - 8*i -: 8]);
            if (i < 5) repeat (gap) step(1'b0, 8'h00);
        end
    endtask

    typedef struct {
        bit          junk;
        logic [47:0] frame;
        int          gap;
        logic        exp_vld;
        logic        exp_err;
        logic [7:0]  exp_cmd;
        logic [23:0] exp_addr;
    } vec_t;

    vec_t vt[6];

    initial begin
        int tmo_seen;
        rst_n   = 1'b0;
        rx_vld  = 1'b0;
        rx_data = 8'h00;
        model_reset();

        vt[0] = '{1'b0, 48'h55A13F00009E, 0,  1'b1, 1'b0, 8'hA1, 24'h3F0000};
        vt[1] = '{1'b0, 48'h55A2400000FF, 0,  1'b0, 1'b1, 8'hA1, 24'h3F0000};
        vt[2] = '{1'b1, 48'h55B3410000F2, 0,  1'b1, 1'b0, 8'hB3, 24'h410000};
        vt[3] = '{1'b0, 48'h55A63F000099, 99, 1'b1, 1'b0, 8'hA6, 24'h3F0000};
        vt[4] = '{1'b0, 48'h55A4420000E6, 0,  1'b1, 1'b0, 8'hA4, 24'h420000};
        vt[5] = '{1'b0, 48'h55C7010203C7, 0,  1'b1, 1'b0, 8'hC7, 24'h010203};

        repeat (2) @(negedge clk);
        check("reset_state", 64'({o_cmd_vld, o_err, o_timeout, o_busy, o_cmd, o_addr}), 64'd0);
        rst_n = 1'b1;

        // Table: good, bad checksum, junk before frame, every gap at the terminal count, back-to-back pair.
        for (int i = 0; i < 6; i++) begin
            if (vt[i].junk) begin
                step(1'b1, 8'h12);
                step(1'b1, 8'h34);
            end
            send_frame(vt[i].frame, vt[i].gap);
            check("vec_vld",  64'(o_cmd_vld), 64'(vt[i].exp_vld));
            check("vec_err",  64'(o_err),     64'(vt[i].exp_err));
            check("vec_cmd",  64'(o_cmd),     64'(vt[i].exp_cmd));
            check("vec_addr", 64'(o_addr),    64'(vt[i].exp_addr));
        end

        // Timeout after a partial frame, then recovery.
        step(1'b1, 8'h55);
        step(1'b1, 8'hA3);
        tmo_seen = 0;
        repeat (100) begin
            step(1'b0, 8'h00);
            if (o_timeout) tmo_seen++;
        end
        check("tmo_pulses", 64'(tmo_seen), 64'd1);
        check("tmo_busy",   64'(o_busy),   64'd0);
        send_frame(48'h55A4420000E6, 0);
        check("tmo_recover", 64'({o_cmd_vld, o_cmd, o_addr}), 64'({1'b1, 8'hA4, 24'h420000}));

        // Reset in the middle of a frame.
        step(1'b1, 8'h55);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3F);
        rst_n  = 1'b0;
        rx_vld = 1'b0;
        #1;
        check("rst_async", 64'({o_cmd_vld, o_err, o_timeout, o_busy, o_cmd, o_addr}), 64'd0);
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("rst_hold", 64'({o_cmd_vld, o_err, o_timeout, o_busy, o_cmd, o_addr}), 64'd0);
        end
        rst_n = 1'b1;
        send_frame(48'h55A13F00009E, 0);
        check("rst_recover", 64'({o_cmd_vld, o_cmd, o_addr}), 64'({1'b1, 8'hA1, 24'h3F0000}));

        // Random traffic: stray bytes, whole frames (some corrupted), short and long idle gaps.
        for (int it = 0; it < 150; it++) begin
            int unsigned r;
            logic [7:0]  c;
            logic [23:0] a;
            logic [7:0]  k;
            r = $urandom_range(0, 9);
            if (r < 4) begin
                step(1'b1, ($urandom_range(0, 3) == 0) ? 8'h55 : 8'($urandom));
            end else if (r < 7) begin
                c = 8'($urandom);
                a = 24'($urandom);
                k = c ^ a[23:16] ^ a[15:8] ^ a[7:0];
                if (r == 6) k = k ^ 8'(1 << $urandom_range(0, 7));
                send_frame({8'h55, c, a, k}, int'($urandom_range(0, 2)));
            end else if (r < 9) begin
                repeat ($urandom_range(1, 5)) step(1'b0, 8'($urandom));
            end else begin
                repeat ($urandom_range(95, 105)) step(1'b0, 8'h00);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 The block SHALL expose parameter HEAD, default 8'h55, the frame start byte.
REQ-002 The block SHALL expose parameter TIMEOUT_CYC, default 16'd50000, the inter-byte timeout in i_clk cycles; legal range 2..65535.
REQ-003 i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  asynchronous, active-low reset; assertion is immediate, release is synchronous to i_clk.
REQ-005 i_rx_data  input  8  received UART byte; sampled only when i_rx_vld=1.
REQ-006 i_rx_vld  input  1  one-cycle strobe marking a valid i_rx_data byte.
REQ-007 o_cmd  output  8  decoded command byte; drives the command input of the downstream address translator.
REQ-008 o_addr  output  24  decoded address, MSB byte first on the wire.
REQ-009 o_cmd_vld  output  1  one-cycle pulse; o_cmd and o_addr are valid in that cycle.
REQ-010 o_err  output  1  one-cycle pulse on checksum mismatch.
REQ-011 o_timeout  output  1  one-cycle pulse on an inter-byte timeout abort.
REQ-012 o_busy  output  1  1 whenever the state is not IDLE.

Function
REQ-013 Frame format SHALL be six bytes: HEAD, CMD, A[23:16], A[15:8], A[7:0], CHK, with CHK = CMD^A[23:16]^A[15:8]^A[7:0].
REQ-014 The FSM SHALL have states IDLE, CMD, ADDR2, ADDR1, ADDR0 and CHK, and SHALL advance exactly one state per accepted byte.
REQ-015 In IDLE, a byte equal to HEAD SHALL move the FSM to CMD; any other byte SHALL be discarded with no output.
REQ-016 In CMD, ADDR2, ADDR1 and ADDR0, the byte SHALL be captured into an internal shadow register and XORed into a running checksum, which is cleared on entry to CMD.
REQ-017 A HEAD value received after IDLE SHALL be treated as data; there is no mid-frame resync.
REQ-018 In CHK, if the byte equals the running checksum, o_cmd and o_addr SHALL load from the shadow registers and o_cmd_vld SHALL pulse high in the following cycle (1-cycle latency from the CHK-byte strobe).
REQ-019 In CHK on a mismatch, o_err SHALL pulse with the same latency, and o_cmd and o_addr SHALL keep their previous values.
REQ-020 After CHK, the FSM SHALL return to IDLE regardless of the checksum result.
REQ-021 o_cmd and o_addr SHALL hold their values until the next good frame.
REQ-022 A 16-bit timeout counter SHALL clear on every i_rx_vld and in IDLE, and SHALL increment every cycle otherwise.
REQ-023 When the timeout counter reaches TIMEOUT_CYC-1 with no strobe, the FSM SHALL return to IDLE and o_timeout SHALL pulse for one cycle; the shadow registers are discarded.
REQ-024 If i_rx_vld coincides with the terminal count, the byte SHALL win: it is accepted and no timeout occurs.
REQ-025 Back-to-back strobes on consecutive cycles SHALL be accepted without loss; a HEAD byte in the cycle right after the CHK byte SHALL start a new frame.
REQ-026 o_cmd_vld, o_err and o_timeout SHALL be mutually exclusive in any cycle.

Reset
REQ-027 On i_rst=0: state=IDLE; o_cmd=8'h00; o_addr=24'h000000; o_cmd_vld=o_err=o_timeout=o_busy=0; checksum, shadow registers and timeout counter = 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame with no output pulse; the first frame after release SHALL decode normally.

Verification
REQ-029 Good frame: 55 A1 3F 00 00 9E -> o_cmd_vld for exactly 1 cycle, o_cmd=A1, o_addr=3F0000, o_err=0.
REQ-030 Bad checksum: 55 A2 40 00 00 FF -> o_err for 1 cycle, no o_cmd_vld, o_cmd/o_addr still A1/3F0000.
REQ-031 Junk in IDLE: 12 34 then 55 B3 41 00 00 F2 -> junk ignored, o_cmd_vld with o_cmd=B3, o_addr=410000.
REQ-032 Timeout (TIMEOUT_CYC=100): 55 A3, then 100 idle cycles -> o_timeout pulse, o_busy=0; the next good frame 55 A4 42 00 00 E6 decodes.
REQ-033 Boundary/reset: a strobe exactly at the terminal count is accepted with no timeout; i_rst low after 55 A5 3F -> outputs return to reset values, no pulse, and the next frame decodes.
REQ-034 Back-to-back: two good frames on consecutive-cycle strobes -> two o_cmd_vld pulses carrying the correct values.
